// File: rtl/fir_requant_decim_if.sv
//------------------------------------------------------------------------------
// Module   : fir_requant_decim_if
// Brief    : AXI-Stream input (32-bit) and output (16-bit) bundle for the
//            FIR requantise/decimate stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fir_requant_decim_if;
  logic [31:0] s_axis_rq_tdata;
  logic [3:0]  s_axis_rq_tkeep;
  logic        s_axis_rq_tlast;
  logic        s_axis_rq_tvalid;
  logic        s_axis_rq_tready;
  logic [15:0] m_axis_rq_tdata;
  logic [1:0]  m_axis_rq_tkeep;
  logic        m_axis_rq_tlast;
  logic        m_axis_rq_tvalid;
  logic        m_axis_rq_tready;

  // Upstream producer / downstream consumer side
  modport master (
    output s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast, s_axis_rq_tvalid,
    input  s_axis_rq_tready,
    input  m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tlast, m_axis_rq_tvalid,
    output m_axis_rq_tready
  );

  // Requantiser side
  modport slave (
    input  s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast, s_axis_rq_tvalid,
    output s_axis_rq_tready,
    output m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tlast, m_axis_rq_tvalid,
    input  m_axis_rq_tready
  );
endinterface

`default_nettype wire

// File: rtl/fir_requant_decim.sv
//------------------------------------------------------------------------------
// Module   : fir_requant_decim
// Brief    : Keeps 1 of every DECIM beats (tlast always kept), rounds/shifts
//            and saturates to 16-bit, buffers through a 2-entry output FIFO.
//            Define FIR_REQUANT_ROUND_EN for round-half-up, else truncation.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir_requant_decim #(
  parameter int DECIM = 4,
  parameter int SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_requant_decim_if.slave   rq,
  output logic                 sat_flag
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

`ifdef FIR_REQUANT_ROUND_EN
  localparam logic signed [32:0] C_ROUND_BIAS = 33'sd1 <<< (SHIFT - 1);
`else
  localparam logic signed [32:0] C_ROUND_BIAS = 33'sd0;
`endif

  logic        r_s_tready;
  logic        w_accept;
  logic        w_phase_zero;
  logic        w_keep;
  logic        w_pop;
  logic [1:0]  r_count;
  logic [1:0]  w_count_nxt;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [16:0] r_mem [2];

  logic signed [32:0] w_ext;
  logic signed [32:0] w_sum;
  logic signed [32:0] w_shifted;
  logic               w_sat_hi;
  logic               w_sat_lo;
  logic [15:0]        w_q;
  logic               w_unused;

  assign w_accept = rq.s_axis_rq_tvalid & r_s_tready;
  assign w_keep   = w_accept & (w_phase_zero | rq.s_axis_rq_tlast);
  assign w_pop    = (r_count != 2'd0) & rq.m_axis_rq_tready;

  generate
    if (DECIM > 1) begin : g_phase
      logic [PW-1:0] r_phase;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_phase <= '0;
        end else if (w_accept) begin
          if (rq.s_axis_rq_tlast || (r_phase == PW'(DECIM - 1)))
            r_phase <= '0;
          else
            r_phase <= r_phase + 1'b1;
        end
      end

      assign w_phase_zero = (r_phase == '0);
    end else begin : g_no_phase
      assign w_phase_zero = 1'b1;
    end
  endgenerate

  // 33-bit sign extension keeps the rounding add from wrapping
  assign w_ext     = {rq.s_axis_rq_tdata[31], rq.s_axis_rq_tdata};
  assign w_sum     = w_ext + C_ROUND_BIAS;
  assign w_shifted = w_sum >>> SHIFT;
  assign w_sat_hi  = (w_shifted > 33'sd32767);
  assign w_sat_lo  = (w_shifted < -33'sd32768);
  assign w_q       = w_sat_hi ? 16'h7FFF : (w_sat_lo ? 16'h8000 : w_shifted[15:0]);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_keep, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_s_tready <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      if (w_keep) begin
        r_mem[r_wr_ptr] <= {rq.s_axis_rq_tlast, w_q};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count    <= w_count_nxt;
      r_s_tready <= (w_count_nxt < 2'd2);
      if (w_keep && (w_sat_hi || w_sat_lo)) sat_flag <= 1'b1;
    end
  end

  assign rq.s_axis_rq_tready = r_s_tready;
  assign rq.m_axis_rq_tvalid = (r_count != 2'd0);
  assign rq.m_axis_rq_tdata  = r_mem[r_rd_ptr][15:0];
  assign rq.m_axis_rq_tlast  = r_mem[r_rd_ptr][16];
  assign rq.m_axis_rq_tkeep  = 2'b11;

  assign w_unused = ^rq.s_axis_rq_tkeep;

endmodule

`default_nettype wire

// File: tb/tb_fir_requant_decim.sv
//------------------------------------------------------------------------------
// Module   : tb_fir_requant_decim
// Brief    : Directed checks of fir_requant_decim with DECIM=1 and DECIM=4.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_requant_decim;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sat_a, sat_b;
  int   checks = 0;
  int   failures = 0;
  logic [16:0] q_a[$];
  logic [16:0] q_b[$];
  int   acc_a = 0;
  int   acc_b = 0;

  always #5 clk = ~clk;

  fir_requant_decim_if ifa();
  fir_requant_decim_if ifb();

  fir_requant_decim #(.DECIM(1), .SHIFT(15)) u_a (.clk(clk), .reset(reset), .rq(ifa), .sat_flag(sat_a));
  fir_requant_decim #(.DECIM(4), .SHIFT(15)) u_b (.clk(clk), .reset(reset), .rq(ifb), .sat_flag(sat_b));

  // Handshakes observed mid-cycle, completing at the next rising edge
  always @(negedge clk) begin
    if (!reset) begin
      if (ifa.m_axis_rq_tvalid && ifa.m_axis_rq_tready) q_a.push_back({ifa.m_axis_rq_tlast, ifa.m_axis_rq_tdata});
      if (ifb.m_axis_rq_tvalid && ifb.m_axis_rq_tready) q_b.push_back({ifb.m_axis_rq_tlast, ifb.m_axis_rq_tdata});
      if (ifa.s_axis_rq_tvalid && ifa.s_axis_rq_tready) acc_a++;
      if (ifb.s_axis_rq_tvalid && ifb.s_axis_rq_tready) acc_b++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  function automatic logic [15:0] model(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
`ifdef FIR_REQUANT_ROUND_EN
    v = v + 64'sd16384;
`endif
    v = v >>> 15;
    if (v > 64'sd32767) return 16'h7FFF;
    if (v < -64'sd32768) return 16'h8000;
    return v[15:0];
  endfunction

  // One beat into the DECIM=1 instance; returns what appears after the accept edge
  task automatic a_one(input logic [31:0] d, output logic [15:0] got, output logic vld);
    ifa.s_axis_rq_tdata  = d;
    ifa.s_axis_rq_tvalid = 1'b1;
    tick();
    ifa.s_axis_rq_tvalid = 1'b0;
    vld = ifa.m_axis_rq_tvalid;
    got = ifa.m_axis_rq_tdata;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (ifa.s_axis_rq_tready !== 1'b0) begin failures++; $display("FAIL rst_s_tready got=%b exp=0", ifa.s_axis_rq_tready); end
    checks++; if (ifa.m_axis_rq_tvalid !== 1'b0) begin failures++; $display("FAIL rst_m_tvalid got=%b exp=0", ifa.m_axis_rq_tvalid); end
    checks++; if (ifa.m_axis_rq_tdata !== 16'h0000) begin failures++; $display("FAIL rst_m_tdata got=%h exp=0000", ifa.m_axis_rq_tdata); end
    checks++; if (ifa.m_axis_rq_tlast !== 1'b0) begin failures++; $display("FAIL rst_m_tlast got=%b exp=0", ifa.m_axis_rq_tlast); end
    checks++; if (sat_a !== 1'b0) begin failures++; $display("FAIL rst_sat got=%b exp=0", sat_a); end
    checks++; if (ifa.m_axis_rq_tkeep !== 2'b11) begin failures++; $display("FAIL rst_tkeep got=%b exp=11", ifa.m_axis_rq_tkeep); end
    reset = 1'b0;
    checks++; if (ifb.s_axis_rq_tready !== 1'b0) begin failures++; $display("FAIL rst_tready_pre_edge got=%b exp=0", ifb.s_axis_rq_tready); end
    tick();
    checks++; if (ifa.s_axis_rq_tready !== 1'b1) begin failures++; $display("FAIL rst_tready_after got=%b exp=1", ifa.s_axis_rq_tready); end
  endtask

  task automatic test_rounding;
    logic [31:0] vin [5];
    logic [15:0] vexp [5];
    logic [15:0] got;
    logic vld;
    vin = '{32'h0000_4000, 32'hFFFF_C000, 32'h0001_8000, 32'h3FFF_0000, 32'hFFFE_8000};
`ifdef FIR_REQUANT_ROUND_EN
    vexp = '{16'h0001, 16'h0000, 16'h0003, 16'h7FFE, 16'hFFFD};
`else
    vexp = '{16'h0000, 16'hFFFF, 16'h0003, 16'h7FFE, 16'hFFFD};
`endif
    for (int i = 0; i < 5; i++) begin
      a_one(vin[i], got, vld);
      checks++; if (vld !== 1'b1) begin failures++; $display("FAIL round_valid[%0d] got=%b exp=1", i, vld); end
      checks++; if (got !== vexp[i]) begin failures++; $display("FAIL round_data[%0d] in=%h got=%h exp=%h", i, vin[i], got, vexp[i]); end
    end
  endtask

  task automatic test_saturation;
    logic [15:0] got;
    logic vld;
    do_reset();
    a_one(32'h4000_0000, got, vld);
    checks++; if (got !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got=%h exp=7fff", got); end
    checks++; if (sat_a !== 1'b1) begin failures++; $display("FAIL sat_pos_flag got=%b exp=1", sat_a); end
    do_reset();
    checks++; if (sat_a !== 1'b0) begin failures++; $display("FAIL sat_cleared got=%b exp=0", sat_a); end
    a_one(32'hC000_0000, got, vld);
    checks++; if (got !== 16'h8000) begin failures++; $display("FAIL sat_minexact got=%h exp=8000", got); end
    checks++; if (sat_a !== 1'b0) begin failures++; $display("FAIL sat_minexact_flag got=%b exp=0", sat_a); end
    a_one(32'h8000_0000, got, vld);
    checks++; if (got !== 16'h8000) begin failures++; $display("FAIL sat_neg got=%h exp=8000", got); end
    checks++; if (sat_a !== 1'b1) begin failures++; $display("FAIL sat_neg_flag got=%b exp=1", sat_a); end
  endtask

  task automatic test_decimation(input logic with_last);
    logic [16:0] exp[$];
    int errs;
    if (with_last) exp = '{17'h00001, 17'h00005, 17'h10006, 17'h00007, 17'h0000B};
    else           exp = '{17'h00001, 17'h00005, 17'h00009};
    q_b.delete();
    acc_b = 0;
    ifb.m_axis_rq_tready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      ifb.s_axis_rq_tdata  = 32'(i) << 15;
      ifb.s_axis_rq_tlast  = with_last && (i == 6);
      ifb.s_axis_rq_tvalid = 1'b1;
      tick();
    end
    ifb.s_axis_rq_tvalid = 1'b0;
    ifb.s_axis_rq_tlast  = 1'b0;
    repeat (4) tick();
    checks++; if (acc_b !== 12) begin failures++; $display("FAIL decim_accepts last=%b got=%0d exp=12", with_last, acc_b); end
    checks++; if (q_b.size() !== exp.size()) begin failures++; $display("FAIL decim_count last=%b got=%0d exp=%0d", with_last, q_b.size(), exp.size()); end
    errs = 0;
    for (int i = 0; i < exp.size() && i < q_b.size(); i++) if (q_b[i] !== exp[i]) errs++;
    checks++; if (errs !== 0) begin failures++; $display("FAIL decim_values last=%b got=%0d wrong entries exp=0", with_last, errs); end
  endtask

  task automatic test_backpressure;
    int k;
    int errs;
    logic acc;
    do_reset();
    q_a.delete();
    acc_a = 0;
    k = 1;
    ifa.m_axis_rq_tready = 1'b0;
    ifa.s_axis_rq_tdata  = 32'(k) << 15;
    ifa.s_axis_rq_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      acc = ifa.s_axis_rq_tready;
      tick();
      if (acc) begin k++; ifa.s_axis_rq_tdata = 32'(k) << 15; end
    end
    checks++; if (acc_a !== 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", acc_a); end
    checks++; if (ifa.s_axis_rq_tready !== 1'b0) begin failures++; $display("FAIL bp_tready got=%b exp=0", ifa.s_axis_rq_tready); end
    checks++; if (ifa.m_axis_rq_tdata !== 16'h0001 || ifa.m_axis_rq_tvalid !== 1'b1) begin
      failures++; $display("FAIL bp_hold got=%b/%h exp=1/0001", ifa.m_axis_rq_tvalid, ifa.m_axis_rq_tdata); end
    ifa.m_axis_rq_tready = 1'b1;
    for (int c = 0; c < 200 && k <= 20; c++) begin
      acc = ifa.s_axis_rq_tready;
      tick();
      if (acc) begin k++; ifa.s_axis_rq_tdata = 32'(k) << 15; end
    end
    ifa.s_axis_rq_tvalid = 1'b0;
    for (int c = 0; c < 20 && q_a.size() < 20; c++) tick();
    checks++; if (q_a.size() !== 20) begin failures++; $display("FAIL bp_out_count got=%0d exp=20", q_a.size()); end
    errs = 0;
    for (int i = 0; i < q_a.size(); i++) if (q_a[i] !== {1'b0, 16'(i + 1)}) errs++;
    checks++; if (errs !== 0) begin failures++; $display("FAIL bp_order got=%0d wrong entries exp=0", errs); end
  endtask

  task automatic test_random_tready;
    logic [16:0] exp[$];
    logic [31:0] d;
    logic acc;
    int n;
    do_reset();
    q_a.delete();
    n = 0;
    d = $urandom;
    ifa.s_axis_rq_tdata  = d;
    ifa.s_axis_rq_tvalid = 1'b1;
    for (int c = 0; c < 6000 && n < 1000; c++) begin
      ifa.m_axis_rq_tready = 1'($urandom_range(0, 1));
      acc = ifa.s_axis_rq_tready;
      tick();
      if (acc) begin
        exp.push_back({1'b0, model(d)});
        n++;
        d = $urandom;
        if (d[0]) d = 32'($signed(d) >>> 9);
        ifa.s_axis_rq_tdata = d;
      end
    end
    ifa.s_axis_rq_tvalid = 1'b0;
    ifa.m_axis_rq_tready = 1'b1;
    for (int c = 0; c < 20 && q_a.size() < exp.size(); c++) tick();
    checks++; if (n !== 1000) begin failures++; $display("FAIL rand_accepted got=%0d exp=1000", n); end
    checks++; if (q_a.size() !== exp.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", q_a.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp[i]) begin failures++; $display("FAIL rand_beat[%0d] got=%h exp=%h", i, q_a[i], exp[i]); end
    end
  endtask

  task automatic test_reset_midstream;
    do_reset();
    ifa.m_axis_rq_tready = 1'b0;
    ifb.m_axis_rq_tready = 1'b1;
    ifa.s_axis_rq_tvalid = 1'b1;
    ifb.s_axis_rq_tvalid = 1'b1;
    ifa.s_axis_rq_tdata  = 32'h4000_0000;
    ifb.s_axis_rq_tdata  = 32'(3) << 15;
    tick();
    ifa.s_axis_rq_tdata  = 32'h0000_8000;
    ifb.s_axis_rq_tdata  = 32'(4) << 15;
    tick();
    ifa.s_axis_rq_tvalid = 1'b0;
    ifb.s_axis_rq_tvalid = 1'b0;
    checks++; if (ifa.m_axis_rq_tvalid !== 1'b1 || sat_a !== 1'b1) begin
      failures++; $display("FAIL mid_prefill got=%b/%b exp=1/1", ifa.m_axis_rq_tvalid, sat_a); end
    q_a.delete();
    q_b.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (ifa.m_axis_rq_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid got=%b exp=0", ifa.m_axis_rq_tvalid); end
    checks++; if (sat_a !== 1'b0) begin failures++; $display("FAIL mid_sat got=%b exp=0", sat_a); end
    tick();
    checks++; if (ifb.s_axis_rq_tready !== 1'b1) begin failures++; $display("FAIL mid_tready got=%b exp=1", ifb.s_axis_rq_tready); end
    ifa.m_axis_rq_tready = 1'b1;
    ifb.s_axis_rq_tdata  = 32'(7) << 15;
    ifb.s_axis_rq_tvalid = 1'b1;
    tick();
    ifb.s_axis_rq_tvalid = 1'b0;
    repeat (3) tick();
    checks++; if (q_b.size() !== 1 || q_b[0] !== 17'h00007) begin
      failures++; $display("FAIL mid_first_kept got_n=%0d got=%h exp=1 beat 00007", q_b.size(), (q_b.size() > 0) ? q_b[0] : 17'h0); end
    checks++; if (q_a.size() !== 0) begin failures++; $display("FAIL mid_discard got=%0d beats exp=0", q_a.size()); end
  endtask

  initial begin
    ifa.s_axis_rq_tdata = '0; ifa.s_axis_rq_tkeep = 4'hF; ifa.s_axis_rq_tlast = 1'b0;
    ifa.s_axis_rq_tvalid = 1'b0; ifa.m_axis_rq_tready = 1'b1;
    ifb.s_axis_rq_tdata = '0; ifb.s_axis_rq_tkeep = 4'hF; ifb.s_axis_rq_tlast = 1'b0;
    ifb.s_axis_rq_tvalid = 1'b0; ifb.m_axis_rq_tready = 1'b1;
    test_reset();
    test_rounding();
    test_saturation();
    do_reset();
    test_decimation(1'b0);
    test_decimation(1'b1);
    test_backpressure();
    test_random_tready();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_requant_decim.md
# fir_requant_decim

Downstream stage of the 15-tap FIR. Accepts the filter's 32-bit signed AXI-Stream output and keeps one beat in every DECIM. Each kept beat is rounded, right-shifted by SHIFT and saturated to 16-bit signed. The result goes out on an AXI-Stream master through a 2-entry output buffer, so full backpressure is honoured without losing beats.

## Interface
- DECIM, 4: decimation ratio, 1..16; DECIM=1 passes every beat.
- SHIFT, 15: arithmetic right shift applied before saturation, 1..16.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- s_axis_rq_tdata  in  32  signed FIR output sample.
- s_axis_rq_tkeep  in  4  ignored.
- s_axis_rq_tlast  in  1  end of frame.
- s_axis_rq_tvalid  in  1  input beat valid.
- s_axis_rq_tready  out  1  input beat accepted when high with tvalid.
- m_axis_rq_tdata  out  16  signed requantised sample.
- m_axis_rq_tkeep  out  2  constant 2'b11.
- m_axis_rq_tlast  out  1  end of frame.
- m_axis_rq_tvalid  out  1  output beat valid.
- m_axis_rq_tready  in  1  downstream accept.
- sat_flag  out  1  sticky: any emitted sample saturated since reset.

## Operation
- Accept: s_axis_rq_tvalid & s_axis_rq_tready at a rising edge.
- Phase counter, 0..DECIM-1, advances on each accept and wraps to 0.
  - An accepted beat is kept when phase==0; otherwise it is dropped.
  - An accepted beat with tlast=1 is always kept, carries tlast=1, and forces phase to 0. The next accepted beat is therefore kept.
- Requant of a kept beat x (32-bit signed):
  - With rounding: y = (x + 2^(SHIFT-1)) >>> SHIFT, computed in 33 bits so the add cannot wrap.
  - Without rounding: y = x >>> SHIFT.
  - If y > 32767, output 0x7FFF. If y < -32768, output 0x8000. Either case sets sat_flag.
  - Otherwise output y[15:0].
- Output buffer: 2-entry FIFO of {tdata, tlast}.
  - Push: kept beat.
  - Pop: m_axis_rq_tvalid & m_axis_rq_tready.
  - m_axis_rq_tdata and m_axis_rq_tlast come from the head entry.
- s_axis_rq_tready is a register holding (next_count < 2). Because count cannot exceed 2 and dropped beats need no space, the tready rule never loses a beat.
- Push and pop in the same cycle: count unchanged, order preserved.
- Reset, including mid-frame: FIFO flushed, phase=0, sat_flag=0. Pending outputs are discarded without tlast.

## Timing
- Reset values:
  - s_axis_rq_tready=0 while reset is high, then 1 from the first edge after reset falls.
  - m_axis_rq_tvalid=0, m_axis_rq_tdata=0, m_axis_rq_tlast=0, sat_flag=0.
  - m_axis_rq_tkeep=2'b11 at all times.
- Latency: a kept beat accepted at edge N appears on m_axis_rq_* after edge N, provided the FIFO was empty.
- Throughput: one input beat per cycle while m_axis_rq_tready=1.
- Master side: m_axis_rq_tdata and m_axis_rq_tlast hold stable while m_axis_rq_tvalid=1 and m_axis_rq_tready=0.
- FIFO full (count=2): s_axis_rq_tready=0 from the following cycle. It returns to 1 the cycle after a pop.
- sat_flag rises the cycle after the saturating beat is accepted.

## Configuration
- FIR_REQUANT_ROUND_EN defined: round-half-up (add 2^(SHIFT-1) before the shift).
- Not defined: truncation toward −∞ (plain arithmetic shift).
- Saturation, decimation and tlast handling are identical in both builds.

## Test plan
- Test parameters are SHIFT=15, DECIM=1 unless a line says otherwise.
- Rounding: input 0x00004000 → 0x0001 with FIR_REQUANT_ROUND_EN, 0x0000 without. Input 0xFFFFC000 → 0x0000 with, 0xFFFF without.
- Saturation: 0x40000000 → 0x7FFF and sat_flag=1. After reset, 0xC0000000 → 0x8000 and sat_flag stays 0. 0x80000000 → 0x8000 and sat_flag=1.
- Decimation with DECIM=4: stream 1<<15 .. 12<<15 continuously → outputs 1, 5, 9.
  - tlast on input 6: outputs 1, 5, 6 (tlast=1), then the next input 7 is kept.
- Backpressure: m_axis_rq_tready=0 for 10 cycles with DECIM=1 under continuous input.
  - Exactly 2 beats are accepted, then s_axis_rq_tready=0.
  - On release, all beats emerge in order with no duplicates or drops.
  - Random tready at 50% over 1000 beats matches the reference model.
- Reset mid-stream: assert reset for 1 cycle with 2 beats buffered.
  - m_axis_rq_tvalid=0 after that edge.
  - The phase restart makes the first post-reset beat kept.
  - sat_flag cleared.
